// File: rtl/bit_sweep_pkg.sv
// Shared types and constants for the bit sweep generator.
package bit_sweep_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    // Output function select codes.
    localparam logic [1:0] MODE_INV  = 2'd0;
    localparam logic [1:0] MODE_PASS = 2'd1;
    localparam logic [1:0] MODE_PAR  = 2'd2;
    localparam logic [1:0] MODE_NPAR = 2'd3;

    // Even parity (XOR reduction) of a zero-extended pattern up to 16 bits.
    function automatic logic even_parity(input logic [15:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/bit_sweep_gen_sweep_fn.sv
// Combinational bit function of the sweep count: invert/pass a selected
// bit or produce even/odd parity. Out-of-range selects fall back to bit 0.
module sweep_fn
    import bit_sweep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SELW  = $clog2(WIDTH)
) (
    input  logic [1:0]       mode,
    input  logic [SELW-1:0]  sel,
    input  logic [WIDTH-1:0] count,
    output logic             f
);

    logic [SELW-1:0] idx_s;
    logic            bit_s;
    logic            par_s;

    // Clamp the bit index so selects beyond the pattern width read bit 0.
    always_comb begin
        idx_s = '0;
        if (int'(sel) < WIDTH) begin
            idx_s = sel;
        end else begin
            idx_s = '0;
        end
    end

    // Pick the selected bit and the parity of the whole pattern.
    always_comb begin
        bit_s = count[idx_s];
        par_s = even_parity(16'(count));
    end

    // Apply the requested output function.
    always_comb begin
        f = 1'b0;
        case (mode)
            MODE_INV:  f = ~bit_s;
            MODE_PASS: f = bit_s;
            MODE_PAR:  f = par_s;
            MODE_NPAR: f = ~par_s;
            default:   f = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_sweep_gen.sv
// Sweep generator: steps a WIDTH-bit counter 0..MAX in one-shot or
// continuous mode under start/stop control and registers a 1-bit
// function of the pre-edge count every cycle. All outputs are registered.
module bit_sweep_gen
    import bit_sweep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SELW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] count,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    sweep_state_e     state_r;
    sweep_state_e     state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic             cont_r;
    logic             cont_s;
    logic             wrap_r;
    logic             wrap_s;
    logic             x_r;
    logic             fn_s;
    logic             busy_r;
    logic             done_r;

    sweep_fn #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_fn (
        .mode  (mode),
        .sel   (sel),
        .count (count_r),
        .f     (fn_s)
    );

    // Next-state, next-count and wrap decode; stop takes priority over start.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        cont_s  = cont_r;
        wrap_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (start) begin
                    state_s = RUN;
                    count_s = '0;
                    cont_s  = cont;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (en) begin
                    if (count_r == MAX) begin
                        if (cont_r) begin
                            count_s = '0;
                            wrap_s  = 1'b1;
                        end else begin
                            state_s = DONE;
                        end
                    end else begin
                        count_s = count_r + ONE;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= '0;
            cont_r  <= 1'b0;
            wrap_r  <= 1'b0;
            x_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            cont_r  <= cont_s;
            wrap_r  <= wrap_s;
            x_r     <= fn_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    assign count = count_r;
    assign x     = x_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign wrap  = wrap_r;

endmodule

// File: tb/tb_bit_sweep_gen.sv
// Self-checking bench for bit_sweep_gen: a vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_bit_sweep_gen;

    localparam int W    = 4;
    localparam int MAXV = 15;

    logic       clk = 1'b0;
    logic       rst, start, stop, cont, en;
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] count;
    logic       x, busy, done, wrap;

    logic       rst_b, start_b, stop_b, cont_b, en_b;
    logic [1:0] mode_b;
    logic [2:0] sel_b;
    logic [4:0] count_b;
    logic       x_b, busy_b, done_b, wrap_b;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int m_cnt;
    bit m_x, m_run, m_fin, m_cont, m_wrap;

    always #5 clk = ~clk;

    bit_sweep_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .en(en), .mode(mode), .sel(sel), .count(count), .x(x),
        .busy(busy), .done(done), .wrap(wrap)
    );

    bit_sweep_gen #(.WIDTH(5)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b), .cont(cont_b),
        .en(en_b), .mode(mode_b), .sel(sel_b), .count(count_b), .x(x_b),
        .busy(busy_b), .done(done_b), .wrap(wrap_b)
    );

    typedef struct {
        bit       rst, start, stop, cont, en;
        bit [1:0] mode, sel;
        int       e_cnt;
        bit       e_x, e_busy, e_done, e_wrap;
    } vec_t;

    vec_t tbl[11];

    function automatic bit ref_f(int md, int s, int c, int w);
        int b;
        int p;
        if (s >= w) s = 0;
        b = (c >> s) % 2;
        p = $countones(c) % 2;
        case (md)
            0:       return (b == 0);
            1:       return (b == 1);
            2:       return (p == 1);
            default: return (p == 0);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit nx;
        if (rst) begin
            m_cnt = 0; m_x = 0; m_run = 0; m_fin = 0; m_cont = 0; m_wrap = 0;
        end else begin
            nx     = ref_f(int'(mode), int'(sel), m_cnt, W);
            m_wrap = 0;
            if (stop) begin
                m_run = 0; m_fin = 0;
            end else if (!m_run && start) begin
                m_run = 1; m_fin = 0; m_cnt = 0; m_cont = cont;
            end else if (m_run && en) begin
                if (m_cnt == MAXV) begin
                    if (m_cont) begin
                        m_cnt = 0; m_wrap = 1;
                    end else begin
                        m_run = 0; m_fin = 1;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_x = nx;
        end
    endtask

    // One clock edge on DUT A, model advanced, all outputs compared.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("count", int'(count), m_cnt);
        chk("x", int'(x), int'(m_x));
        chk("busy", int'(busy), int'(m_run));
        chk("done", int'(done), int'(m_fin));
        chk("wrap", int'(wrap), int'(m_wrap));
    endtask

    task automatic edge_b();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps;
        int first_wrap;
        int second_wrap;

        rst = 1; start = 0; stop = 0; cont = 0; en = 0; mode = 0; sel = 0;
        rst_b = 1; start_b = 0; stop_b = 0; cont_b = 0; en_b = 0; mode_b = 0; sel_b = 0;

        // ---- WIDTH=5 instance: select clamping (A held in reset) ----
        edge_b();
        chk("b_reset_count", int'(count_b), 0);
        rst_b = 0; start_b = 1;
        edge_b();
        chk("b_start_busy", int'(busy_b), 1);
        start_b = 0; en_b = 1;
        for (int i = 0; i < 6; i++) edge_b();
        en_b = 0;
        chk("b_count6", int'(count_b), 6);
        mode_b = 0; sel_b = 3'd5; edge_b(); chk("b_inv_sel5_clamp", int'(x_b), 1);
        sel_b = 3'd7;             edge_b(); chk("b_inv_sel7_clamp", int'(x_b), 1);
        sel_b = 3'd2;             edge_b(); chk("b_inv_sel2", int'(x_b), 0);
        mode_b = 1; sel_b = 3'd6; edge_b(); chk("b_pass_sel6_clamp", int'(x_b), 0);
        sel_b = 3'd1;             edge_b(); chk("b_pass_sel1", int'(x_b), 1);

        // ---- Vector table on DUT A ----
        //           rst st sp ct en md sl  cnt x  bsy dn wr
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 1, 0,  2, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 2, 0,  3, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 2, 0,  3, 0, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 1, 1, 1,  4, 1, 1, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 1, 0, 2,  4, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 1, 2,  4, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 0, 2, 0,  4, 1, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 3, 0,  0, 0, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
            cont = tbl[i].cont; en = tbl[i].en; mode = tbl[i].mode; sel = tbl[i].sel;
            tick();
            chk("tbl_count", int'(count), tbl[i].e_cnt);
            chk("tbl_x", int'(x), int'(tbl[i].e_x));
            chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
            chk("tbl_done", int'(done), int'(tbl[i].e_done));
            chk("tbl_wrap", int'(wrap), int'(tbl[i].e_wrap));
        end
        rst = 0; start = 0; stop = 0; cont = 0; en = 0; mode = 0; sel = 0;

        // ---- Reset mid-sweep ----
        start = 1; tick();
        start = 0; en = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("midsweep_count5", int'(count), 5);
        rst = 1; tick(); rst = 0;
        chk("midrst_count", int'(count), 0);
        chk("midrst_x", int'(x), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_wrap", int'(wrap), 0);

        // ---- One-shot full sweep ----
        mode = 0; sel = 0; cont = 0; en = 0; start = 1;
        tick();
        chk("oneshot_start_count", int'(count), 0);
        chk("oneshot_start_busy", int'(busy), 1);
        start = 0; en = 1;
        for (int n = 1; n <= 15; n++) begin
            tick();
            chk("oneshot_count", int'(count), n);
            chk("oneshot_x", int'(x), ((n - 1) % 2 == 0) ? 1 : 0);
        end
        tick();
        chk("oneshot_done", int'(done), 1);
        chk("oneshot_busy_low", int'(busy), 0);
        chk("oneshot_hold15", int'(count), 15);
        tick();
        chk("oneshot_hold15_b", int'(count), 15);

        // ---- Restart from DONE, continuous mode ----
        start = 1; cont = 1;
        tick();
        chk("restart_count", int'(count), 0);
        chk("restart_done", int'(done), 0);
        chk("restart_busy", int'(busy), 1);
        start = 0; cont = 0;
        wraps = 0; first_wrap = -1; second_wrap = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (wrap) begin
                wraps++;
                if (first_wrap < 0) first_wrap = i; else second_wrap = i;
                chk("wrap_count0", int'(count), 0);
                chk("wrap_busy", int'(busy), 1);
            end
        end
        chk("wrap_total", wraps, 2);
        chk("wrap_first_edge", first_wrap, 16);
        chk("wrap_period", second_wrap - first_wrap, 16);

        // ---- en gating and start+stop together ----
        stop = 1; tick(); stop = 0;
        chk("stop_busy", int'(busy), 0);
        start = 1; en = 0; tick(); start = 0;
        en = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("gate_count7", int'(count), 7);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gate_hold7", int'(count), 7);
        end
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        chk("startstop_busy", int'(busy), 0);
        chk("startstop_count", int'(count), 7);

        // ---- Modes at count 0110 ----
        start = 1; tick(); start = 0; en = 1;
        for (int i = 0; i < 6; i++) tick();
        en = 0;
        chk("modes_count6", int'(count), 6);
        mode = 2;           tick(); chk("mode_par", int'(x), 0);
        mode = 3;           tick(); chk("mode_npar", int'(x), 1);
        mode = 1; sel = 2;  tick(); chk("mode_pass_sel2", int'(x), 1);
        mode = 0; sel = 1;  tick(); chk("mode_inv_sel1", int'(x), 0);

        // ---- Randomized run against the model ----
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 7) == 0);
            cont  = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 3) != 0);
            mode  = 2'($urandom_range(0, 3));
            sel   = 2'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_sweep_gen.md
# bit_sweep_gen

Parametrised sweep generator with a registered bit-function output, successor to the single-bit inverter stage. It steps a WIDTH-bit counter through every value 0..2^WIDTH-1, in one-shot or continuous mode, under a start/stop handshake. Each cycle it produces a registered 1-bit function of the current count: invert a selected bit, pass a selected bit, or even/odd parity. It sits between the lab stimulus logic and the unit under test, so sweeps run in hardware instead of from bench delays.

## Interface
- WIDTH, 4: counter and pattern width; legal range 2..16.
- SELW, $clog2(WIDTH): width of the bit-select port (derived; do not override).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep (sampled in IDLE or DONE).
- stop  in  1  abort the sweep and return to IDLE.
- cont  in  1  1 = continuous (wrap forever), 0 = one-shot; sampled with start.
- en  in  1  advance enable in RUN.
- mode  in  2  output function: 0 = ~count[sel], 1 = count[sel], 2 = ^count, 3 = ~^count.
- sel  in  SELW  bit index for modes 0/1; values ≥ WIDTH select bit 0.
- count  out  WIDTH  current sweep value.
- x  out  1  registered function output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (one-shot finished).
- wrap  out  1  one-cycle pulse on a continuous-mode wrap MAX→0.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: count=0, x=0, busy=0, done=0, wrap=0, latched cont=0.
- IDLE: count holds. start → RUN, count←0, cont latched.
- RUN, en=1, count<MAX: count←count+1.
- RUN, en=1, count=MAX, latched cont=1: count←0, wrap←1 for one cycle, stay in RUN.
- RUN, en=1, count=MAX, latched cont=0: → DONE, count holds MAX.
- RUN, en=0: count and state hold. wrap←0.
- DONE: done=1, count holds. start → RUN with count←0 (restart). stop → IDLE.
- stop in RUN → IDLE, count holds its last value.
- start and stop in the same cycle: stop wins.
- start in RUN is ignored. The cont input is ignored outside the start cycle.
- x←f(mode, sel, count) every non-reset edge, from the pre-edge count. This applies in all states.
- mode and sel may change any cycle. They affect x from the next edge.
- Arithmetic: count is unsigned WIDTH bits. MAX = 2^WIDTH−1. There is no carry out other than wrap.

## Timing
- start at edge k: busy=1 and count=0 after k.
- With en held high, count=n after edge k+n.
- One-shot: done=1 after edge k+2^WIDTH. busy falls at the same edge.
- x latency is one cycle: x after edge j equals f(count after edge j−1).
- wrap is high for exactly the cycle following the edge where count goes MAX→0.
- rst at any edge overrides all other inputs. This includes mid-sweep: all outputs return to their reset values after that edge.
- No combinational path from inputs to outputs.

## Structure
- Package bit_sweep_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - mode constants MODE_INV, MODE_PASS, MODE_PAR, MODE_NPAR.
- Sub-module sweep_fn (combinational): computes f(mode, sel, count) with sel clamping.
- The top-level module holds the FSM, the counter, and the output registers.

## Test plan
- Reset mid-sweep: WIDTH=4; start, 5 en cycles (count=5); assert rst → next edge count=0, x=0, busy=0, done=0, wrap=0, state IDLE.
- One-shot full sweep: WIDTH=4, mode=0, sel=0, cont=0, en=1.
  - count steps 0..15.
  - x sequence is ~count[0] delayed one cycle.
  - done=1 at start+16 edges; count holds 15.
- Continuous wrap: cont=1, en=1 → after count 15 the next value is 0, wrap pulses one cycle, busy stays 1. The second wrap follows 16 edges later.
- en gating / stop: en low for 3 cycles at count=7 → count stays 7. start+stop together at count=7 → IDLE, count stays 7.
- Modes and clamping at count=0b0110:
  - mode 2 → x=0; mode 3 → x=1.
  - mode 1, sel=2 → x=1.
  - mode 0, sel=5 (≥WIDTH, clamps to bit 0) → x=1.
- Restart from DONE: after the one-shot completes, start → count=0, done=0, busy=1 on the next edge.
